// File: rtl/dvp_pattern_source.sv
`timescale 1ns/1ps
// dvp_pattern_source
// DVP-style camera stream transmitter producing test patterns with exact,
// parameterized frame geometry (VSYNC / VBACK / ACTIVE / VFRONT line periods).
//
// Ports:
//   PixelClk   in   1   pixel clock, one pixel per cycle
//   reset      in   1   asynchronous, active-high reset
//   enable     in   1   run request; sampled in IDLE and on the last VFRONT cycle
//   pat_sel    in   2   pattern select, latched on VSYNC entry
//   pixdata    out  8   pixel value, 0 whenever hsync is 0
//   hsync      out  1   line-valid, 1 during active pixels
//   vsync      out  1   frame sync, 1 during the VSYNC line periods
//   frame_done out  1   one-cycle pulse on the first blank cycle after the last pixel
//   frame_cnt  out  16  completed frame count, wraps
//
// Build option: define DVP_SRC_LFSR_EN to replace pattern 3 (moving bar) with
// an 8-bit LFSR noise pattern reseeded at every frame start.
module dvp_pattern_source #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int H_BLANK   = 144,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic        PixelClk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pat_sel,
  output logic [7:0]  pixdata,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int          LINE_CYC = IMG_W + H_BLANK;
  localparam logic [15:0] H_LAST   = 16'(LINE_CYC - 1);
  localparam logic [15:0] H_ACT    = 16'(IMG_W);
  localparam logic [15:0] VS_LAST  = 16'(VS_LINES - 1);
  localparam logic [15:0] VBP_LAST = 16'(VBP_LINES - 1);
  localparam logic [15:0] ACT_LAST = 16'(IMG_H - 1);
  localparam logic [15:0] VFP_LAST = 16'(VFP_LINES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFRONT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] hcnt_q, hcnt_d;       // cycle within the line period
  logic [15:0] vcnt_q, vcnt_d;       // line within the current state
  logic [1:0]  pat_q, pat_d;
  logic [7:0]  pixdata_q, pixdata_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        line_end;
  logic [15:0] lines_last;
  logic        start_frame;
  logic        active_px;
  logic [9:0]  x10;
  logic [9:0]  y10;
  logic [7:0]  pat_pix;

  // Last line index of whichever vertical state is running.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    lines_last = VS_LAST;
    case (state_q)
      ST_VBACK:  lines_last = VBP_LAST;
      ST_ACTIVE: lines_last = ACT_LAST;
      ST_VFRONT: lines_last = VFP_LAST;
      default:   lines_last = VS_LAST;
    endcase
  end

  // Frame sequencer.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    pat_d       = pat_q;
    start_frame = 1'b0;
    line_end    = (hcnt_q == H_LAST);
    if (state_q == ST_IDLE) begin
      hcnt_d = '0;
      vcnt_d = '0;
      start_frame = enable;
    end else begin
      hcnt_d = line_end ? '0 : hcnt_q + 16'd1;
      if (line_end) begin
        vcnt_d = vcnt_q + 16'd1;
        if (vcnt_q == lines_last) begin
          vcnt_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            default: begin
              // End of VFRONT: chain straight into the next frame or stop.
              if (enable) start_frame = 1'b1;
              else        state_d     = ST_IDLE;
            end
          endcase
        end
      end
    end
    if (start_frame) begin
      state_d = ST_VSYNC;
      pat_d   = pat_sel;
    end
  end

  assign active_px = (state_q == ST_ACTIVE) && (hcnt_q < H_ACT);
  assign x10       = hcnt_q[9:0];
  assign y10       = vcnt_q[9:0];

`ifdef DVP_SRC_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; steps once per emitted pixel.
  always_comb begin
    lfsr_d = lfsr_q;
    if (start_frame)    lfsr_d = 8'hA5;
    else if (active_px) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end
`else
  logic [9:0] bar_x;

  // 10-bit truncating x + 4*frame_cnt; the bar slides 4 pixels per frame.
  assign bar_x = x10 + {frame_cnt_q[7:0], 2'b00};
`endif

  // Output stage: everything is computed from the current counters and
  // registered, so pixdata and hsync leave the block in the same cycle.
  always_comb begin
    pat_pix = 8'h00;
    case (pat_q)
      2'd0:    pat_pix = x10[9:2];
      2'd1:    pat_pix = y10[8:1];
      2'd2:    pat_pix = {8{x10[5] ^ y10[5]}};
`ifdef DVP_SRC_LFSR_EN
      default: pat_pix = lfsr_q;
`else
      default: pat_pix = {8{bar_x[5]}};
`endif
    endcase
    pixdata_d    = active_px ? pat_pix : 8'h00;
    hsync_d      = active_px;
    vsync_d      = (state_q == ST_VSYNC);
    frame_done_d = (state_q == ST_ACTIVE) && (vcnt_q == ACT_LAST) && (hcnt_q == H_ACT);
    frame_cnt_d  = frame_cnt_q + {15'd0, frame_done_d};
  end

  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      pat_q        <= 2'd0;
      pixdata_q    <= 8'h00;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, independent of statement order.
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      pat_q        <= pat_d;
      pixdata_q    <= pixdata_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign pixdata    = pixdata_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_dvp_pattern_source.sv
`timescale 1ns/1ps
// Testbench for dvp_pattern_source.
// Small-geometry instance: scoreboard of expected events (vsync edges, every
// active pixel, frame_done) generated per frame from the frame rules; a
// monitor pops and compares whenever the DUT shows an event.
// Default-geometry instance: checkerboard sample points.
module tb_dvp_pattern_source;

  localparam int W = 8, H = 4, HB = 4, VS = 1, VBP = 1, VFP = 1;
  localparam int LC    = W + HB;
  localparam int FRAME = (VS + VBP + H + VFP) * LC;

  localparam int BW   = 640;
  localparam int BLC  = 784;
  localparam int BPRE = 20;   // default VS_LINES + VBP_LINES

`ifdef DVP_SRC_LFSR_EN
  localparam bit LFSR_BUILD = 1'b1;
`else
  localparam bit LFSR_BUILD = 1'b0;
`endif

  localparam int EV_NONE = 0, EV_VSR = 1, EV_VSF = 2, EV_PIX = 3, EV_DONE = 4;

  typedef struct {
    int kind;
    int t;
    int val;
  } ev_s;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Small instance
  logic        rst_s, en_s;
  logic [1:0]  pat_s;
  logic [7:0]  pix_s;
  logic        hs_s, vs_s, fd_s;
  logic [15:0] fc_s;

  dvp_pattern_source #(
    .IMG_W(W), .IMG_H(H), .H_BLANK(HB),
    .VS_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)
  ) u_small (
    .PixelClk(clk), .reset(rst_s), .enable(en_s), .pat_sel(pat_s),
    .pixdata(pix_s), .hsync(hs_s), .vsync(vs_s), .frame_done(fd_s), .frame_cnt(fc_s)
  );

  // Default-geometry instance
  logic        rst_b, en_b;
  logic [1:0]  pat_b;
  logic [7:0]  pix_b;
  logic        hs_b, vs_b, fd_b;
  logic [15:0] fc_b;

  dvp_pattern_source u_big (
    .PixelClk(clk), .reset(rst_b), .enable(en_b), .pat_sel(pat_b),
    .pixdata(pix_b), .hsync(hs_b), .vsync(vs_b), .frame_done(fd_b), .frame_cnt(fc_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit done_s = 1'b0;
  bit done_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] ref_pix(input int pat, input int x, input int y, input int fc);
    case (pat)
      0:       return 8'((x / 4) % 256);
      1:       return 8'((y / 2) % 256);
      2:       return (((x / 32) % 2) != ((y / 32) % 2)) ? 8'hFF : 8'h00;
      default: return ((((x + 4 * fc) % 1024) / 32) % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // ---------------- reference model (small instance) ----------------
  ev_s         exp_q[$];
  int          next_free = 0;
  logic [15:0] fc_m = 16'd0;

  // Frame starting with enable sampled at edge s: outputs appear from s+1.
  task automatic push_frame(input int s, input int pat);
    int base, act0;
    logic [7:0] l;
    logic [7:0] v;
    base = s + 1;
    act0 = base + (VS + VBP) * LC;
    exp_q.push_back('{EV_VSR, base, 0});
    exp_q.push_back('{EV_VSF, base + VS * LC, 0});
    l = 8'hA5;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        v = (pat == 3 && LFSR_BUILD) ? l : ref_pix(pat, x, y, int'(fc_m));
        exp_q.push_back('{EV_PIX, act0 + y * LC + x, int'(v)});
        l = lfsr_step(l);
      end
    end
    fc_m = fc_m + 16'd1;
    exp_q.push_back('{EV_DONE, act0 + (H - 1) * LC + W, int'(fc_m)});
    next_free = s + FRAME;
  endtask

  always @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      exp_q.delete();
      next_free = 0;
      fc_m = 16'd0;
    end else if (cyc >= next_free && en_s) begin
      push_frame(cyc, int'(pat_s));
    end
  end

  // ---------------- monitor (small instance) ----------------
  logic pv_s = 1'b0;
  int   mon_fc = 0;

  always @(negedge clk) begin
    int  t;
    int  kind;
    ev_s e;
    if (rst_s) begin
      pv_s = 1'b0;
      mon_fc = 0;
    end else begin
      t = cyc - 1;
      while (exp_q.size() > 0 && exp_q[0].t < t) begin
        check("missed_event_time", exp_q[0].t, t);
        void'(exp_q.pop_front());
      end
      kind = EV_NONE;
      if (hs_s)              kind = EV_PIX;
      else if (fd_s)         kind = EV_DONE;
      else if (vs_s && !pv_s) kind = EV_VSR;
      else if (!vs_s && pv_s) kind = EV_VSF;
      if (kind != EV_NONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event_kind", kind, EV_NONE);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", kind, e.kind);
          check("event_time", t, e.t);
          if (kind == EV_PIX) check("pixdata", pix_s, e.val);
          if (kind == EV_DONE) begin
            check("frame_cnt_at_done", fc_s, e.val);
            mon_fc = e.val;
          end
        end
      end
      check("hsync_vsync_overlap", hs_s & vs_s, 0);
      if (!hs_s) check("blank_pixdata", pix_s, 0);
      if (!fd_s) check("frame_cnt_stable", fc_s, mon_fc);
      pv_s = vs_s;
    end
  end

  // Big instance: blank cycles always carry 0.
  always @(negedge clk) begin
    if (!rst_b) begin
      if (!hs_b) check("big_blank_pixdata", pix_b, 0);
      check("big_hsync_vsync_overlap", hs_b & vs_b, 0);
    end
  end

  // Drive so that the next sampling edge has index k.
  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- small-instance stimulus ----------------
  initial begin
    int s0;
    int budget;
    rst_s = 1'b1;
    en_s  = 1'b0;
    pat_s = 2'd0;
    #2;
    check("rst_pixdata", pix_s, 0);
    check("rst_hsync", hs_s, 0);
    check("rst_vsync", vs_s, 0);
    check("rst_frame_done", fd_s, 0);
    check("rst_frame_cnt", fc_s, 0);
    @(negedge clk);
    @(negedge clk);
    rst_s = 1'b0;

    // Pattern 0 frame, pat_sel switched to 1 mid-ACTIVE, then stop in VBACK.
    @(posedge clk);
    #1;
    s0 = cyc;
    en_s = 1'b1;
    goto(s0 + 45);
    pat_s = 2'd1;
    goto(s0 + FRAME + 15);
    en_s = 1'b0;
    goto(s0 + 2 * FRAME + 100);
    @(negedge clk);
    check("stop_frame_cnt", fc_s, 2);
    check("stop_vsync", vs_s, 0);
    check("stop_hsync", hs_s, 0);
    check("stop_pixdata", pix_s, 0);

    // Randomized run: pattern changes and enable toggling.
    @(posedge clk);
    #1;
    en_s = 1'b1;
    repeat (2500) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 29) == 0) pat_s = 2'($urandom_range(0, 3));
      if (en_s && $urandom_range(0, 299) == 0)     en_s = 1'b0;
      else if (!en_s && $urandom_range(0, 39) == 0) en_s = 1'b1;
    end

    // Reset in the middle of an active line.
    en_s = 1'b1;
    budget = 400;
    while (!hs_s && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("reach_active_before_reset", hs_s, 1);
    #2;
    rst_s = 1'b1;
    #1;
    check("async_rst_pixdata", pix_s, 0);
    check("async_rst_hsync", hs_s, 0);
    check("async_rst_vsync", vs_s, 0);
    check("async_rst_frame_done", fd_s, 0);
    check("async_rst_frame_cnt", fc_s, 0);
    pat_s = 2'd3;
    @(negedge clk);
    @(negedge clk);
    rst_s = 1'b0;

    // Pattern 3 frames back to back, then stop and drain.
    goto(cyc + 3 * FRAME);
    en_s = 1'b0;
    goto(cyc + FRAME + 50);
    check("events_left", exp_q.size(), 0);
    done_s = 1'b1;
  end

  // ---------------- default-geometry checkerboard ----------------
  initial begin
    int sb, base, t;
    int px[8], py[8];
    rst_b = 1'b1;
    en_b  = 1'b0;
    pat_b = 2'd2;
    px = '{0, 1, 32, 639, 640, 783, 0, 32};
    py = '{0, 0, 0, 0, 0, 31, 32, 32};
    @(negedge clk);
    rst_b = 1'b0;
    en_b  = 1'b1;
    sb = cyc;
    base = sb + 1 + BPRE * BLC;
    while (cyc - 1 < sb) @(negedge clk);
    check("big_vsync_before_rise", vs_b, 0);
    while (cyc - 1 < sb + 1) @(negedge clk);
    check("big_vsync_rise", vs_b, 1);
    en_b = 1'b0;
    while (cyc - 1 < sb + 3 * BLC) @(negedge clk);
    check("big_vsync_last", vs_b, 1);
    @(negedge clk);
    check("big_vsync_fall", vs_b, 0);
    for (int i = 0; i < 8; i++) begin
      t = base + py[i] * BLC + px[i];
      while (cyc - 1 < t) @(negedge clk);
      check($sformatf("big_hsync_x%0d_y%0d", px[i], py[i]), hs_b, (px[i] < BW) ? 1 : 0);
      check($sformatf("big_pix_x%0d_y%0d", px[i], py[i]), pix_b,
            (px[i] < BW) ? ref_pix(2, px[i], py[i], 0) : 8'h00);
    end
    done_b = 1'b1;
  end

  initial begin
    wait (done_s && done_b);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete (compared %0d, mismatched %0d)", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
